ro_enc_multi: RTL and testbench

Parametrised successor to the single front-panel rotary encoder decoder. Serves N_CH quadrature encoders. Each channel has:
- input synchronisation and debounce
- x4 Gray-code decoding
- a saturating signed position counter, last-direction flag and illegal-transition flag

A combined level IRQ goes to the PS. Counters and IRQ are cleared through AXI-driven clear strobes. Sits between the front-panel encoder pins and the AXI4-Lite register block.

---
 rtl/ro_enc_multi_if.sv | 27 ++
 rtl/ro_enc_multi.sv | 150 +++++++++++++++
 tb/tb_ro_enc_multi.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ro_enc_multi_if.sv
// Bus bundle between the encoder decoder and its AXI-side register block.
interface ro_enc_multi_if #(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned CNT_W = 8
);
  logic [N_CH-1:0]       enc_a;
  logic [N_CH-1:0]       enc_b;
  logic                  clear;
  logic [N_CH-1:0]       ch_clear;
  logic [N_CH*CNT_W-1:0] cnt;
  logic [N_CH-1:0]       dir;
  logic [N_CH-1:0]       irq_ch;
  logic                  irq;
  logic [N_CH-1:0]       err;

  // Register block / pin side: drives encoder pins and clear strobes.
  modport master (
    output enc_a, enc_b, clear, ch_clear,
    input  cnt, dir, irq_ch, irq, err
  );

  // Decoder side.
  modport slave (
    input  enc_a, enc_b, clear, ch_clear,
    output cnt, dir, irq_ch, irq, err
  );
endinterface

// File: rtl/ro_enc_multi.sv
// Multi-channel quadrature encoder decoder: sync, debounce, x4 decode,
// saturating signed counters, sticky step/error flags and a combined IRQ.
module ro_enc_multi #(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned DB_CYC = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  ro_enc_multi_if.slave  bus
);

  localparam int unsigned NBit = 2 * N_CH;
  localparam int unsigned DbW  = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DB_CYC - 1);
  localparam logic signed [CNT_W-1:0] CntMax = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic signed [CNT_W-1:0] CntMin = {1'b1, {(CNT_W-1){1'b0}}};

  // Bit i < N_CH is A of channel i, bit N_CH+i is B of channel i.
  logic [NBit-1:0] raw;
  logic [NBit-1:0] meta_q;
  logic [NBit-1:0] sync_q;
  logic [NBit-1:0] filt_q;
  logic [DbW-1:0]  db_q [NBit];

  logic [1:0]              cur [N_CH];
  logic [1:0]              prev_q [N_CH];
  logic [N_CH-1:0]         primed_q;
  logic signed [CNT_W-1:0] cnt_q [N_CH];
  logic [N_CH-1:0]         dir_q;
  logic [N_CH-1:0]         irq_ch_q;
  logic [N_CH-1:0]         err_q;
  logic                    irq_q;

  logic [N_CH-1:0] chg;
  logic [N_CH-1:0] step_cw;
  logic [N_CH-1:0] step_ccw;
  logic [N_CH-1:0] illegal;

  assign raw = {bus.enc_b, bus.enc_a};

  // Position of a {A,B} state along the CW Gray sequence 00-10-11-01.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   gray_pos = 2'd0;
      2'b10:   gray_pos = 2'd1;
      2'b11:   gray_pos = 2'd2;
      default: gray_pos = 2'd3;
    endcase
  endfunction

  // Two-stage synchroniser for every raw pin.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
    end
  end

  // Per-bit debounce: accept a new level only after DB_CYC differing cycles.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      filt_q <= '0;
      for (int i = 0; i < NBit; i++) db_q[i] <= '0;
    end else begin
      for (int i = 0; i < NBit; i++) begin
        if (sync_q[i] == filt_q[i]) begin
          db_q[i] <= '0;
        end else if (db_q[i] == DbLast) begin
          filt_q[i] <= sync_q[i];
          db_q[i]   <= '0;
        end else begin
          db_q[i] <= db_q[i] + DbW'(1);
        end
      end
    end
  end

  // Classify the filtered transition of each channel against its previous state.
  always_comb begin
    chg      = '0;
    step_cw  = '0;
    step_ccw = '0;
    illegal  = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      cur[ch] = {filt_q[ch], filt_q[N_CH+ch]};
      chg[ch] = (cur[ch] != prev_q[ch]);
      // Unprimed channels only latch their first state.
      if (chg[ch] && primed_q[ch]) begin
        unique case (2'(gray_pos(cur[ch]) - gray_pos(prev_q[ch])))
          2'd1:    step_cw[ch]  = 1'b1;
          2'd3:    step_ccw[ch] = 1'b1;
          default: illegal[ch]  = 1'b1;
        endcase
      end
    end
  end

  // Counters and sticky flags; a clear beats a coincident step.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      primed_q <= '0;
      dir_q    <= '0;
      irq_ch_q <= '0;
      err_q    <= '0;
      irq_q    <= 1'b0;
      for (int ch = 0; ch < N_CH; ch++) begin
        prev_q[ch] <= '0;
        cnt_q[ch]  <= '0;
      end
    end else begin
      irq_q <= |irq_ch_q;
      for (int ch = 0; ch < N_CH; ch++) begin
        if (chg[ch]) begin
          prev_q[ch]   <= cur[ch];
          primed_q[ch] <= 1'b1;
        end
        if (bus.clear || bus.ch_clear[ch]) begin
          cnt_q[ch]    <= '0;
          irq_ch_q[ch] <= 1'b0;
          err_q[ch]    <= 1'b0;
        end else if (step_cw[ch]) begin
          dir_q[ch]    <= 1'b0;
          irq_ch_q[ch] <= 1'b1;
          if (cnt_q[ch] != CntMax) cnt_q[ch] <= cnt_q[ch] + CNT_W'(1);
        end else if (step_ccw[ch]) begin
          dir_q[ch]    <= 1'b1;
          irq_ch_q[ch] <= 1'b1;
          if (cnt_q[ch] != CntMin) cnt_q[ch] <= cnt_q[ch] - CNT_W'(1);
        end else if (illegal[ch]) begin
          err_q[ch] <= 1'b1;
        end
      end
    end
  end

  // Pack per-channel state onto the bus.
  always_comb begin
    bus.cnt = '0;
    for (int ch = 0; ch < N_CH; ch++) bus.cnt[ch*CNT_W +: CNT_W] = cnt_q[ch];
    bus.dir    = dir_q;
    bus.irq_ch = irq_ch_q;
    bus.err    = err_q;
    bus.irq    = irq_q;
  end

endmodule

// File: tb/tb_ro_enc_multi.sv
// Randomised self-checking bench for ro_enc_multi against a state-sequence model.
module tb_ro_enc_multi;
  localparam int unsigned NCh   = 2;
  localparam int unsigned CntW  = 8;
  localparam int unsigned DbCyc = 4;
  localparam int          CMax  = (1 << (CntW - 1)) - 1;
  localparam int          CMin  = -(1 << (CntW - 1));

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ro_enc_multi_if #(.N_CH(NCh), .CNT_W(CntW)) bus ();

  ro_enc_multi #(.N_CH(NCh), .CNT_W(CntW), .DB_CYC(DbCyc)) dut (
    .i_clk (clk),
    .i_rst (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // CW order of {A,B} states.
  logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  logic [1:0] drv [NCh];
  logic [1:0] m_ab [NCh];
  bit         m_primed [NCh];
  int         m_cnt [NCh];
  bit         m_dir [NCh];
  bit         m_irq [NCh];
  bit         m_err [NCh];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int seq_idx(logic [1:0] ab);
    for (int i = 0; i < 4; i++) if (seq[i] == ab) return i;
    return 0;
  endfunction

  // Model: a newly accepted stable state moves the position by +1, -1 or is illegal.
  function automatic void m_accept(int ch, logic [1:0] ab, bit lost);
    int d;
    if (ab == m_ab[ch]) return;
    if (!m_primed[ch]) begin
      m_primed[ch] = 1'b1;
    end else if (!lost) begin
      d = (seq_idx(ab) - seq_idx(m_ab[ch]) + 4) % 4;
      if (d == 1) begin
        m_dir[ch] = 1'b0;
        m_irq[ch] = 1'b1;
        if (m_cnt[ch] < CMax) m_cnt[ch]++;
      end else if (d == 3) begin
        m_dir[ch] = 1'b1;
        m_irq[ch] = 1'b1;
        if (m_cnt[ch] > CMin) m_cnt[ch]--;
      end else begin
        m_err[ch] = 1'b1;
      end
    end
    m_ab[ch] = ab;
  endfunction

  task automatic set_raw();
    for (int c = 0; c < NCh; c++) begin
      bus.enc_a[c] = drv[c][1];
      bus.enc_b[c] = drv[c][0];
    end
  endtask

  task automatic check_all(string tag);
    logic [NCh-1:0] e_dir, e_irq, e_err;
    for (int c = 0; c < NCh; c++) begin
      check($sformatf("%s cnt%0d", tag, c), 32'(bus.cnt[c*CntW +: CntW]),
            32'(m_cnt[c] & ((1 << CntW) - 1)));
      e_dir[c] = m_dir[c];
      e_irq[c] = m_irq[c];
      e_err[c] = m_err[c];
    end
    check({tag, " dir"}, 32'(bus.dir), 32'(e_dir));
    check({tag, " irq_ch"}, 32'(bus.irq_ch), 32'(e_irq));
    check({tag, " irq"}, 32'(bus.irq), 32'(|e_irq));
    check({tag, " err"}, 32'(bus.err), 32'(e_err));
  endtask

  task automatic settle_check(string tag);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  // Step the masked channels one legal position (CW or CCW) in the same cycle.
  task automatic step_mask(logic [NCh-1:0] mask, logic [NCh-1:0] ccw, int hold);
    logic [1:0] nab [NCh];
    for (int c = 0; c < NCh; c++) nab[c] = seq[(seq_idx(drv[c]) + (ccw[c] ? 3 : 1)) % 4];
    @(posedge clk);
    #1;
    for (int c = 0; c < NCh; c++) begin
      if (mask[c]) begin
        drv[c] = nab[c];
        m_accept(c, nab[c], 1'b0);
      end
    end
    set_raw();
    repeat (hold) @(posedge clk);
  endtask

  task automatic flip_both(int ch);
    @(posedge clk);
    #1;
    drv[ch] = ~drv[ch];
    set_raw();
    m_accept(ch, drv[ch], 1'b0);
  endtask

  // Invert one pin for len sampled cycles, then restore it.
  task automatic glitch(int ch, int bsel, int len);
    logic [1:0] orig;
    orig = drv[ch];
    @(posedge clk);
    #1;
    drv[ch][bsel] = ~drv[ch][bsel];
    set_raw();
    repeat (len) @(posedge clk);
    #1;
    if (len >= DbCyc) begin
      m_accept(ch, drv[ch], 1'b0);
      m_accept(ch, orig, 1'b0);
    end
    drv[ch] = orig;
    set_raw();
  endtask

  task automatic pulse_clear(bit all, logic [NCh-1:0] mask);
    @(posedge clk);
    #1;
    bus.clear    = all;
    bus.ch_clear = mask;
    @(posedge clk);
    #1;
    bus.clear    = 1'b0;
    bus.ch_clear = '0;
    for (int c = 0; c < NCh; c++) begin
      if (all || mask[c]) begin
        m_cnt[c] = 0;
        m_irq[c] = 1'b0;
        m_err[c] = 1'b0;
      end
    end
  endtask

  initial begin
    int lat;
    int op;
    int ch;
    logic [1:0] nab;

    for (int c = 0; c < NCh; c++) begin
      drv[c] = 2'b11;
      m_ab[c] = 2'b00;
      m_primed[c] = 1'b0;
      m_cnt[c] = 0;
      m_dir[c] = 1'b0;
      m_irq[c] = 1'b0;
      m_err[c] = 1'b0;
    end
    bus.clear    = 1'b0;
    bus.ch_clear = '0;
    set_raw();

    // Reset with encoders resting at 11: priming absorbs 00 -> 11.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("in_reset");
    rst_n = 1'b1;
    for (int c = 0; c < NCh; c++) m_accept(c, 2'b11, 1'b0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check_all("after_reset");

    // Ch0 four CW steps; first one timed for latency and IRQ lag.
    step_mask(2'b01, 2'b00, 0);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.cnt[CntW-1:0] != '0) begin
        lat = n;
        break;
      end
    end
    check("first_step_latency", 32'(lat), 32'd7);
    check("first_step_irq_ch", 32'(bus.irq_ch), 32'd1);
    check("first_step_irq_lag", 32'(bus.irq), 32'd0);
    @(negedge clk);
    check("first_step_irq", 32'(bus.irq), 32'd1);
    for (int i = 0; i < 3; i++) step_mask(2'b01, 2'b00, 9);
    settle_check("cw4");

    // Ch1 A glitches: 3 cycles ignored, 4 cycles accepted both ways.
    glitch(1, 1, 3);
    settle_check("glitch3");
    glitch(1, 1, 4);
    settle_check("glitch4");

    // Positive saturation, then one CCW step.
    for (int i = 0; i < 130; i++) step_mask(2'b01, 2'b00, 5);
    settle_check("sat_pos");
    step_mask(2'b01, 2'b01, 5);
    settle_check("ccw_after_sat");

    // Ch0 to 00, then illegal 00 -> 11.
    step_mask(2'b01, 2'b00, 5);
    settle_check("to_00");
    flip_both(0);
    settle_check("illegal");

    // Ch1 clear coinciding with a ch1 step: clear wins.
    step_mask(2'b10, 2'b00, 9);
    settle_check("ch1_pre");
    nab = seq[(seq_idx(drv[1]) + 1) % 4];
    @(posedge clk);
    #1;
    drv[1] = nab;
    set_raw();
    m_accept(1, nab, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    bus.ch_clear = 2'b10;
    @(posedge clk);
    #1;
    bus.ch_clear = '0;
    m_cnt[1] = 0;
    m_irq[1] = 1'b0;
    m_err[1] = 1'b0;
    settle_check("ch_clear_vs_step");
    pulse_clear(1'b1, 2'b00);
    settle_check("global_clear");

    // Negative saturation on ch1.
    for (int i = 0; i < 132; i++) step_mask(2'b10, 2'b10, 5);
    settle_check("sat_neg");

    // Random mix of steps, simultaneous steps, glitches, illegal moves and clears.
    for (int it = 0; it < 150; it++) begin
      op = $urandom_range(0, 9);
      ch = $urandom_range(0, NCh - 1);
      if (op <= 5) begin
        step_mask(NCh'(1 << ch), NCh'($urandom_range(0, 3)), 0);
      end else if (op == 6) begin
        glitch(ch, $urandom_range(0, 1), $urandom_range(1, 3));
      end else if (op == 7) begin
        step_mask(2'b11, NCh'($urandom_range(0, 3)), 0);
      end else if (op == 8) begin
        flip_both(ch);
      end else begin
        pulse_clear(1'($urandom_range(0, 1)), NCh'($urandom_range(0, 3)));
      end
      settle_check($sformatf("rnd%0d op%0d", it, op));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
